segment_reader: RTL
===================

SEGMENT_READER -- requirements
Module: segment_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4 (legal range 2..15); consecutive equal synchronized samples required before a digit is committed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 display  input  8  active-low segment lines {dp,g,f,e,d,c,b,a}; asynchronous to clk.
REQ-005 digit_sel  input  4  active-low anode enables; bit i low selects digit i; asynchronous to clk.
REQ-006 frame_ready  input  1  consumer accepts the presented frame when high with frame_valid.
REQ-007 value  output  16  decoded hex digits, digit i at [4i+3:4i].
REQ-008 overflow  output  4  decoded decimal point per digit; bit i high means dp lit on digit i.
REQ-009 frame_valid  output  1  value/overflow hold a complete, unconsumed frame.
REQ-010 pattern_error  output  1  one-cycle pulse when a committed pattern is not a legal hex glyph.

Function
REQ-011 display and digit_sel SHALL pass through a two-flop synchronizer (s1, s2) before any use.
REQ-012 A third register s3 SHALL hold the previous s2; stability counter cnt SHALL load 0 when s2!=s3 or when s2 digit_sel is not exactly one bit low, else increment, saturating at STABLE_CYCLES.
REQ-013 An arm flag SHALL set whenever cnt loads 0 and clear on commit; a commit SHALL occur once on the edge where cnt==STABLE_CYCLES and arm is set.
REQ-014 Decode: segments inverted to active-high; gfedcba 3F,06,5B,4F,66,6D,7D,07,7F,67,77,7C,39,5E,79,71 map to 0..F; dp inverted gives overflow bit.
REQ-015 Legal commit SHALL write the nibble and overflow bit into internal digit register i and set captured[i]; re-commit of an already captured digit overwrites it.
REQ-016 Illegal commit (any other gfedcba pattern, including all-off) SHALL pulse pattern_error for one cycle and leave digit register i and captured[i] unchanged.
REQ-017 Latency: input held constant from sampling edge k commits at edge k+STABLE_CYCLES+3.
REQ-018 When captured==4'b1111 and the output slot is free (frame_valid low, or frame_valid and frame_ready high), the next edge SHALL copy internal registers to value/overflow, set frame_valid, and clear captured.
REQ-019 Commit and frame load on the same edge: the commit lands in the internal register and sets its captured bit after the clear (captured holds only that bit).
REQ-020 frame_valid high and frame_ready low: value/overflow/frame_valid SHALL hold; capture continues internally; captured stays 4'b1111 once full.
REQ-021 frame_ready with frame_valid high and captured not full SHALL clear frame_valid next edge; value/overflow keep last data.
REQ-022 frame_ready while frame_valid low SHALL have no effect.

Reset
REQ-023 reset high SHALL on the next edge clear s1, s2, s3 to 8'hFF/4'hF (blank, no digit), cnt, arm, captured, internal digit registers, value=16'h0000, overflow=4'h0, frame_valid=0, pattern_error=0.
REQ-024 reset asserted mid-capture or while frame_valid is high SHALL discard all partial and pending data; no frame or error is emitted for pre-reset inputs.

Verification
REQ-025 STABLE_CYCLES=4; drive digit_sel=4'b1110, display=~8'h06 held 20 cycles -> internal digit0=1 committed at edge k+7, exactly one commit, no pattern_error.
REQ-026 Scan digits 0..3 with ~8'h5B, ~8'hCF, ~8'h71, ~8'h3F, 10 cycles each, frame_ready=1 -> frame_valid pulses one cycle, value=16'h0F32, overflow=4'b0010.
REQ-027 digit_sel=4'b1101, display=~8'h49 held 10 cycles -> single pattern_error pulse, captured[1] stays 0, no frame.
REQ-028 Display toggles every 3 cycles (shorter than STABLE_CYCLES) -> no commit, no error, no frame.
REQ-029 Complete frame A with frame_ready=0, then scan frame B -> value holds A; raise frame_ready -> next edge presents B, frame_valid stays 1.
REQ-030 Assert reset after digits 0..2 captured -> all outputs zero next edge; scanning only digit 3 afterwards produces no frame.

Source files
------------

// File: rtl/segment_reader.sv
// segment_reader: samples a multiplexed, active-low 7-segment display plus
// its anode enables and rebuilds the four hex digits and decimal points
// shown on it. Each digit is committed only after its synchronized
// pattern has stayed unchanged long enough. A full set of four digits
// is then presented as one frame through a valid/ready handshake.
module segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  display,
  input  logic [3:0]  digit_sel,
  input  logic        frame_ready,
  output logic [15:0] value,
  output logic [3:0]  overflow,
  output logic        frame_valid,
  output logic        pattern_error
);

  localparam logic [3:0]  STABLE_N = 4'(STABLE_CYCLES);
  // All-high sample: no digit selected and every segment dark.
  localparam logic [11:0] BLANK    = 12'hFFF;

  // Samples are packed as {digit_sel, dp, g, f, e, d, c, b, a}, all active-low.
  logic [11:0] s1_q, s1_d;
  logic [11:0] s2_q, s2_d;
  logic [11:0] s3_q, s3_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        arm_q, arm_d;
  logic [3:0]  captured_q, captured_d;
  logic [15:0] digit_q, digit_d;
  logic [3:0]  dp_q, dp_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  overflow_q, overflow_d;
  logic        frame_valid_q, frame_valid_d;
  logic        pattern_error_q, pattern_error_d;

  logic        sel_ok;
  logic        restart;
  logic        commit;
  logic [1:0]  commit_idx;
  logic [4:0]  glyph;
  logic        frame_load;

  // Returns {legal, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h67:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // True when exactly one anode enable is driven low.
  function automatic logic one_low(input logic [3:0] sel);
    logic r;
    case (sel)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state logic: synchronizer chain, stability tracking, digit commit, frame handshake.
  always_comb begin
    s1_d            = {digit_sel, display};
    s2_d            = s1_q;
    s3_d            = s2_q;
    cnt_d           = cnt_q;
    arm_d           = arm_q;
    captured_d      = captured_q;
    digit_d         = digit_q;
    dp_d            = dp_q;
    value_d         = value_q;
    overflow_d      = overflow_q;
    frame_valid_d   = frame_valid_q;
    pattern_error_d = 1'b0;
    commit_idx      = 2'd0;

    sel_ok  = one_low(s2_q[11:8]);
    restart = (s2_q != s3_q) || !sel_ok;
    // s3 holds the pattern that has just been stable for STABLE_CYCLES compares.
    commit  = (cnt_q == STABLE_N) && arm_q;
    glyph   = decode_glyph(~s3_q[6:0]);

    case (s3_q[11:8])
      4'b1101: commit_idx = 2'd1;
      4'b1011: commit_idx = 2'd2;
      4'b0111: commit_idx = 2'd3;
      default: commit_idx = 2'd0;
    endcase

    if (restart) begin
      cnt_d = 4'd0;
    end else if (cnt_q != STABLE_N) begin
      cnt_d = cnt_q + 4'd1;
    end

    // A fresh pattern re-arms even on a commit edge, since it needs its own commit.
    if (restart) begin
      arm_d = 1'b1;
    end else if (commit) begin
      arm_d = 1'b0;
    end

    frame_load = (captured_q == 4'hF) && (!frame_valid_q || frame_ready);
    if (frame_load) begin
      value_d       = digit_q;
      overflow_d    = dp_q;
      frame_valid_d = 1'b1;
      captured_d    = 4'h0;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    // Applied after the frame load so a same-edge commit starts the next frame.
    if (commit) begin
      if (glyph[4]) begin
        digit_d[{commit_idx, 2'b00} +: 4] = glyph[3:0];
        dp_d[commit_idx]                  = ~s3_q[7];
        captured_d[commit_idx]            = 1'b1;
      end else begin
        pattern_error_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q            <= BLANK;
      s2_q            <= BLANK;
      s3_q            <= BLANK;
      cnt_q           <= 4'd0;
      arm_q           <= 1'b0;
      captured_q      <= 4'h0;
      digit_q         <= 16'h0000;
      dp_q            <= 4'h0;
      value_q         <= 16'h0000;
      overflow_q      <= 4'h0;
      frame_valid_q   <= 1'b0;
      pattern_error_q <= 1'b0;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      s3_q            <= s3_d;
      cnt_q           <= cnt_d;
      arm_q           <= arm_d;
      captured_q      <= captured_d;
      digit_q         <= digit_d;
      dp_q            <= dp_d;
      value_q         <= value_d;
      overflow_q      <= overflow_d;
      frame_valid_q   <= frame_valid_d;
      pattern_error_q <= pattern_error_d;
    end
  end

  assign value         = value_q;
  assign overflow      = overflow_q;
  assign frame_valid   = frame_valid_q;
  assign pattern_error = pattern_error_q;

endmodule
